// File: rtl/demux1_2_reg.sv
// -----------------------------------------------------------------------------
// demux1_2_reg
// Registered 1-to-2 demultiplexer with valid/ready handshake. Each input word
// is steered by in_sel into a one-entry holding register on port 0 or port 1.
// The two ports are independent, so a stalled port never blocks the other.
//
// Parameters
//   N      data width in bits
//   CNT_W  width of the per-port transfer counters (DEMUX_CNT_EN only)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input handshake and word
//   in_sel                      destination port (0 or 1), sampled with in_data
//   out0_valid/ready/data       port 0 holding register and handshake
//   out1_valid/ready/data       port 1 holding register and handshake
//   xfer_cnt0/xfer_cnt1         completed-transfer counts (DEMUX_CNT_EN only)
//
// Build option
//   DEMUX_CNT_EN  when defined, adds the per-port transfer counters and ports.
// -----------------------------------------------------------------------------
module demux1_2_reg #(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [N-1:0]     out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [N-1:0]     out1_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt0,
  output logic [CNT_W-1:0] xfer_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_e;

  port_state_e  state_q [2];
  port_state_e  state_d [2];
  logic [N-1:0] data_q  [2];
  logic [N-1:0] data_d  [2];

  logic [1:0] out_ready;
  logic [1:0] sel_oh;
  logic [1:0] drain;
  logic       accept;

  assign out_ready = {out1_ready, out0_ready};
  assign sel_oh    = {in_sel, ~in_sel};

  // in_ready depends only on the selected port's state and consumer ready,
  // never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      if (sel_oh[k]) begin
        in_ready = (state_q[k] == EMPTY) | out_ready[k];
      end
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      drain[k]   = (state_q[k] == FULL) & out_ready[k];
      // Accept takes priority over drain: a same-cycle drain and reload
      // leaves the port FULL with the new word.
      if (accept & sel_oh[k]) begin
        state_d[k] = FULL;
        data_d[k]  = in_data;
      end else if (drain[k]) begin
        state_d[k] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out0_valid = (state_q[0] == FULL);
  assign out1_valid = (state_q[1] == FULL);
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k];
      if (drain[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt0 = cnt_q[0];
  assign xfer_cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux1_2_reg.sv
// -----------------------------------------------------------------------------
// tb_demux1_2_reg
// Self-checking bench for demux1_2_reg: a vector table of per-cycle inputs with
// expected pre-edge outputs, plus a per-port scoreboard that queues every
// accepted word and compares it when the port hands it off.
// -----------------------------------------------------------------------------
module tb_demux1_2_reg;

  localparam int N     = 16;
  localparam int CNT_W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_sel;
  logic         out0_valid;
  logic         out0_ready;
  logic [N-1:0] out0_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [N-1:0] out1_data;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] xfer_cnt0;
  logic [CNT_W-1:0] xfer_cnt1;
`endif

  demux1_2_reg #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
    ,
    .xfer_cnt0  (xfer_cnt0),
    .xfer_cnt1  (xfer_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then (1 time unit later,
  // still before the rising edge) score any output handoffs and record any
  // accepted input word.
  task automatic step(input logic v, input logic s, input logic [N-1:0] d,
                      input logic r0, input logic r1);
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    if (out0_valid && out0_ready) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb0_unexpected: got %0h expected no word", out0_data);
      end else begin
        chk("sb0_data", 32'(out0_data), 32'(q0.pop_front()));
      end
    end
    if (out1_valid && out1_ready) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb1_unexpected: got %0h expected no word", out1_data);
      end else begin
        chk("sb1_data", 32'(out1_data), 32'(q1.pop_front()));
      end
    end
    if (in_valid && in_ready) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
  endtask

  typedef struct packed {
    logic         v;
    logic         s;
    logic [N-1:0] d;
    logic         r0;
    logic         r1;
    logic         ir;
    logic         v0;
    logic         v1;
    logic [N-1:0] d0;
    logic [N-1:0] d1;
  } vec_t;

  vec_t tbl [12];
  int   vcount;

  initial begin
    // Route, stall, no in_valid->in_ready path, isolation, drain+reload.
    tbl[0]  = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'hABCD};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'hABCD};
    tbl[4]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'hABCD};
    tbl[5]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'hABCD};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'hABCD};
    tbl[7]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'hABCD};
    tbl[8]  = '{1'b1, 1'b1, 16'h00FF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 16'hABCD};
    tbl[9]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h00FF};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h00FF};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h00FF};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #1;
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_d0", 32'(out0_data), 32'd0);
    chk("rst_d1", 32'(out1_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("vec%0d_v0", i), 32'(out0_valid), 32'(tbl[i].v0));
      chk($sformatf("vec%0d_v1", i), 32'(out1_valid), 32'(tbl[i].v1));
      chk($sformatf("vec%0d_d0", i), 32'(out0_data), 32'(tbl[i].d0));
      chk($sformatf("vec%0d_d1", i), 32'(out1_data), 32'(tbl[i].d1));
    end

    // Throughput: words 1..8 back to back into port 1.
    vcount = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, N'(i), 1'b1, 1'b1);
      chk($sformatf("tp%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (out1_valid) vcount++;
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    if (out1_valid) vcount++;
    chk("tp_last_data", 32'(out1_data), 32'h8);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    if (out1_valid) vcount++;
    chk("tp_valid_cycles", 32'(vcount), 32'd8);
    chk("tp_idle_v1", 32'(out1_valid), 32'd0);

    // Reset mid-cycle with port 0 full and stalled.
    step(1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("pre_rst_v0", 32'(out0_valid), 32'd1);
    chk("pre_rst_d0", 32'(out0_data), 32'h5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_v0", 32'(out0_valid), 32'd0);
    chk("midrst_d0", 32'(out0_data), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset sanity: port 0 takes a word again.
    step(1'b1, 1'b0, 16'hC0DE, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("postrst_v0", 32'(out0_valid), 32'd1);
    chk("postrst_d0", 32'(out0_data), 32'hC0DE);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

`ifdef DEMUX_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst0", 32'(xfer_cnt0), 32'd0);
    chk("cnt_rst1", 32'(xfer_cnt1), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 1'b0, N'(i), 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("cnt_wrap0", 32'(xfer_cnt0), 32'd1);
    chk("cnt_wrap1", 32'(xfer_cnt1), 32'd0);
`endif

    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
